// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: default widths, frame state,
// and the parameter legality check used at elaboration.
package mac_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefCoefW = 16;
   localparam int unsigned DefAccW  = 40;
   localparam int unsigned DefOutW  = 16;
   localparam int unsigned DefShift = 15;

   typedef enum logic {
      StIdle = 1'b0,
      StOpen = 1'b1
   } frame_state_e;

   // The accumulator must hold a full product, the shift must leave at least one bit,
   // and the result cannot be wider than the accumulator.
   function automatic bit widths_ok(input int unsigned data_w, input int unsigned coef_w,
                                    input int unsigned acc_w, input int unsigned out_w,
                                    input int unsigned shift);
      return (acc_w >= data_w + coef_w) && (shift < acc_w) && (out_w <= acc_w);
   endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Round-half-up, arithmetic right shift and signed saturation of an accumulator value.
// Purely combinational so it can be dropped into other datapaths.
module mac_round_sat #(
   parameter int unsigned ACC_W = 40,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SHIFT = 15
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] data_o,
   output logic             sat_o
);

   // One extra bit so the rounding increment cannot wrap the most positive sum.
   localparam int unsigned RW = ACC_W + 1;

   logic signed [RW-1:0] ext;
   logic signed [RW-1:0] rnd;
   logic signed [RW-1:0] shifted;
   logic                 fits;

   assign ext = {acc_i[ACC_W-1], acc_i};

   if (SHIFT > 0) begin : g_round
      localparam logic [RW-1:0] Half = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign rnd = ext + Half;
   end else begin : g_no_round
      assign rnd = ext;
   end

   assign shifted = rnd >>> SHIFT;

   // The value fits when every bit above the result's sign bit repeats the sign.
   assign fits = (shifted[RW-1:OUT_W-1] == {(RW-OUT_W+1){shifted[RW-1]}});

   always_comb begin
      data_o = shifted[OUT_W-1:0];
      sat_o  = 1'b0;
      if (!fits) begin
         sat_o  = 1'b1;
         data_o = shifted[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mac_frame_acc.sv
// Framed, pipelined signed multiply-accumulate: product stage, accumulate stage, then a
// rounded/saturated result register with valid/ready handshake and global stall.
module mac_frame_acc
   import mac_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned COEF_W = DefCoefW,
   parameter int unsigned ACC_W  = DefAccW,
   parameter int unsigned OUT_W  = DefOutW,
   parameter int unsigned SHIFT  = DefShift
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_a_i,
   input  logic [COEF_W-1:0] in_b_i,
   input  logic              in_first_i,
   input  logic              in_last_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OUT_W-1:0]  out_data_o,
   output logic              out_sat_o,
   output logic              err_frame_o
);

   if (!widths_ok(DATA_W, COEF_W, ACC_W, OUT_W, SHIFT)) begin : g_bad_widths
      $error("mac_frame_acc: illegal DATA_W/COEF_W/ACC_W/OUT_W/SHIFT combination");
   end

   localparam int unsigned ProdW = DATA_W + COEF_W;

   logic stall;

   // Stage 1: product
   logic signed [ProdW-1:0] a_ext;
   logic signed [ProdW-1:0] b_ext;
   logic signed [ProdW-1:0] prod;
   logic                    s1_valid_q;
   logic [ACC_W-1:0]        s1_prod_q;
   logic                    s1_first_q;
   logic                    s1_last_q;

   // Stage 2: accumulator and frame tracking
   frame_state_e     state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             fin_q, fin_d;
   logic             err_q, err_d;
   logic             fresh;

   // Output register
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             out_sat_q, out_sat_d;
   logic [OUT_W-1:0] rs_data;
   logic             rs_sat;

   assign stall      = out_valid_q && !out_ready_i;
   assign in_ready_o = !stall;

   assign a_ext = ProdW'($signed(in_a_i));
   assign b_ext = ProdW'($signed(in_b_i));
   assign prod  = a_ext * b_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
      end else if (!stall) begin
         s1_valid_q <= in_valid_i;
         s1_prod_q  <= ACC_W'(prod);
         s1_first_q <= in_first_i;
         s1_last_q  <= in_last_i;
      end
   end

   always_comb begin
      acc_d   = acc_q;
      state_d = state_q;
      fin_d   = fin_q;
      err_d   = 1'b0;
      fresh   = 1'b0;
      if (!stall) begin
         fin_d = 1'b0;
         if (s1_valid_q) begin
            // A stray first discards the open sum; a missing first restarts from zero.
            fresh   = s1_first_q || (state_q == StIdle);
            acc_d   = fresh ? s1_prod_q : acc_q + s1_prod_q;
            err_d   = s1_first_q ^ (state_q == StIdle);
            state_d = s1_last_q ? StIdle : StOpen;
            fin_d   = s1_last_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         state_q <= StIdle;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         state_q <= state_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
      end
   end

   mac_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .acc_i  (acc_q),
      .data_o (rs_data),
      .sat_o  (rs_sat)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      if (!stall) begin
         out_valid_d = fin_q;
         if (fin_q) begin
            out_data_d = rs_data;
            out_sat_d  = rs_sat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;
   assign err_frame_o = err_q;

endmodule

// File: tb/tb_mac_frame_acc.sv
// Directed bench for mac_frame_acc with default parameters; expected values hand-computed.
module tb_mac_frame_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        in_first = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_sat;
   logic        err_frame;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int err_cnt  = 0;
   int lat;
   int e0;

   always #5 clk = ~clk;

   mac_frame_acc u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_first_i  (in_first),
      .in_last_i   (in_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_sat_o   (out_sat),
      .err_frame_o (err_frame)
   );

   // Counts high cycles, so a pulse longer than one cycle shows up as an extra count.
   always @(negedge clk) if (err_frame) err_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic f,
                       input logic l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_first = f;
      in_last  = l;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called on a falling edge with out_ready high; returns one falling edge after the result.
   task automatic expect_out(input string tag, input logic [15:0] d, input logic s,
                             output int wait_cyc);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
      chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
      wait_cyc = n;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {16'd0, out_data}, 32'd0);
      chk("rst_sat", {31'd0, out_sat}, 32'd0);
      chk("rst_err", {31'd0, err_frame}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Single-tap frame: 2^28 >> 15 = 0x2000, two cycles after acceptance
      send(16'h4000, 16'h4000, 1'b1, 1'b1);
      idle();
      expect_out("one_tap", 16'h2000, 1'b0, lat);
      chk("one_tap_latency", lat, 32'd2);

      // Rounding: 0x4000 + half rounds up to 1; 0x3FFF + half stays below
      send(16'h0001, 16'h4000, 1'b1, 1'b1);
      idle();
      expect_out("round_up", 16'h0001, 1'b0, lat);
      send(16'h0001, 16'h3FFF, 1'b1, 1'b1);
      idle();
      expect_out("round_down", 16'h0000, 1'b0, lat);

      // Saturation both ways
      send(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
      send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
      send(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
      idle();
      expect_out("sat_pos", 16'h7FFF, 1'b1, lat);
      send(16'h8000, 16'h7FFF, 1'b1, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b0, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b0, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b0, 1'b1);
      idle();
      expect_out("sat_neg", 16'h8000, 1'b1, lat);
      chk("clean_frames_no_err", err_cnt, 32'd0);

      // Backpressure: three 2-tap frames, results 0x4000, 0x2000, 0xF000
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h4000, 16'h4000, 1'b1, 1'b0);
      send(16'h4000, 16'h4000, 1'b0, 1'b1);
      send(16'h2000, 16'h4000, 1'b1, 1'b0);
      send(16'h2000, 16'h4000, 1'b0, 1'b1);
      @(negedge clk);
      in_a     = 16'hF000;
      in_b     = 16'h4000;
      in_first = 1'b1;
      in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_data", {16'd0, out_data}, 32'h4000);
         chk("bp_hold_sat", {31'd0, out_sat}, 32'd0);
         if (i < 4) @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      send(16'hF000, 16'h4000, 1'b0, 1'b1);
      idle();
      expect_out("bp_frame2", 16'h2000, 1'b0, lat);
      expect_out("bp_frame3", 16'hF000, 1'b0, lat);
      chk("bp_no_err", err_cnt, 32'd0);

      // Missing first after reset: one pulse, sum starts from zero
      do_reset();
      e0 = err_cnt;
      send(16'h4000, 16'h4000, 1'b0, 1'b0);
      send(16'h4000, 16'h4000, 1'b0, 1'b1);
      idle();
      expect_out("no_first_rst", 16'h4000, 1'b0, lat);
      chk("no_first_rst_err", err_cnt, e0 + 1);

      // Missing first after a completed frame: old sum must not leak in
      send(16'h0001, 16'h4000, 1'b0, 1'b1);
      idle();
      expect_out("no_first_idle", 16'h0001, 1'b0, lat);
      chk("no_first_idle_err", err_cnt, e0 + 2);

      // First while open: the 0x7FFF^2 partial sum is discarded
      send(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      send(16'h4000, 16'h4000, 1'b1, 1'b0);
      send(16'h4000, 16'h4000, 1'b0, 1'b1);
      idle();
      expect_out("first_mid", 16'h4000, 1'b0, lat);
      chk("first_mid_err", err_cnt, e0 + 3);

      // Reset after 2 of 4 taps: nothing comes out, next clean frame is unaffected
      e0 = err_cnt;
      send(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_rst_no_out", {31'd0, out_valid}, 32'd0);
      end
      send(16'h4000, 16'h4000, 1'b1, 1'b1);
      idle();
      expect_out("after_rst", 16'h2000, 1'b0, lat);
      chk("after_rst_err", err_cnt, e0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
